instr_prefetch_buffer: RTL and testbench
========================================

Name: instr_prefetch_buffer

Overview:
Instruction-side front end that sits directly upstream of the fetch stage. It issues word reads to instruction memory over a req/ack handshake and queues returned words, each tagged with its PC, in a small FIFO. The fetch stage pops instructions from the FIFO. A control-flow redirect from decode or execute flushes the queue, restarts fetching at the new PC, and discards any read still in flight.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
redirect_valid  in  1  flush and restart at redirect_pc (branch taken / jal / jalr)
redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced to 0)
deq_ready  in  1  fetch stage accepts head entry this cycle
instr_valid  out  1  FIFO non-empty
instr  out  32  head instruction word
instr_pc  out  32  PC of head instruction
mem_req  out  1  read request, registered
mem_addr  out  32  read address, registered, word aligned
mem_ack  in  1  read data valid; only meaningful while mem_req=1
mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, FIFO empty (count=0, rd_ptr=wr_ptr=0), state=IDLE, mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0 (head outputs driven 0 when empty).
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, data kept.
  - DROP: request outstanding, data to be discarded.
- Space rule: a request may issue only if count + (request outstanding ? 1 : 0) < DEPTH, evaluated on next-cycle count (including this cycle's push/pop).
- IDLE transitions:
  - IDLE -> WAIT when space and no redirect: mem_req<=1, mem_addr<=fetch_pc.
  - IDLE with redirect: fetch_pc<=redirect_pc, FIFO flushed, stay IDLE; request issues the following cycle.
- Memory protocol: mem_req and mem_addr hold stable until the cycle mem_ack=1. Ack latency is >=1 cycle after req rises, unbounded.
- WAIT, mem_ack=1, no redirect:
  - Push {fetch_pc, mem_rdata}; fetch_pc<=fetch_pc+4 (32-bit wrap from FFFF_FFFC to 0).
  - If space remains, stay WAIT with mem_addr<=fetch_pc+4 (back-to-back, one word per cycle max). Otherwise mem_req<=0 and go to IDLE.
- WAIT, redirect=1, mem_ack=0: go to DROP. mem_req stays 1 with the old mem_addr. FIFO flushed; fetch_pc<=redirect_pc.
- WAIT, redirect=1, mem_ack=1: data discarded, FIFO flushed, fetch_pc<=redirect_pc, mem_req<=0, go to IDLE.
- DROP:
  - On mem_ack: discard data, mem_req<=0, go to IDLE.
  - Another redirect while in DROP: update fetch_pc only; the last redirect wins.
- Dequeue: pop when instr_valid & deq_ready & !redirect_valid. Head outputs are combinational from FIFO storage at rd_ptr.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Redirect has priority over push and pop in the same cycle: the FIFO is emptied and no entry is consumed.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never exceeds DEPTH (guaranteed by the space rule).
- Reset asserted mid-request: mem_req drops immediately. The memory must tolerate an abandoned request.

Test Plan:
- Reset release, RESET_PC=0, mem_ack one cycle after every req, deq_ready=1 -> mem_addr 0,4,8,C in order; instr_pc matches mem_addr; instr equals mem_rdata; instr_valid first high 2 cycles after the first req.
- deq_ready=0, DEPTH=4, ack every cycle -> exactly 4 pushes (addr 0..C); mem_req low after the 4th ack; count=4. Raise deq_ready for 1 cycle -> next request issues to addr 0x10.
- Redirect to 0x100 while in WAIT with ack delayed 3 cycles -> state DROP; returned word not queued; instr_valid=0; next mem_addr=0x100; first instr_pc=0x100.
- Redirect to 0x200 in the same cycle as mem_ack and deq_ready -> no push, no pop; FIFO empty next cycle; next mem_addr=0x200.
- Redirect to 0x203 -> mem_addr=0x200. Separately, fetch_pc=0xFFFF_FFFC -> next fetch address 0x0000_0000.
- Assert rst while mem_req=1 and FIFO holds 2 entries -> mem_req=0, instr_valid=0 immediately (async); after release, first mem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer
// Instruction-side front end that sits directly upstream of the fetch stage.
// It reads words from instruction memory over a req/ack handshake and queues
// each returned word, tagged with its PC, in a DEPTH-entry FIFO. The fetch
// stage pops from the head of that FIFO. A redirect from decode or execute
// empties the queue, restarts fetching at the new PC and throws away any read
// that is still in flight.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   redirect_valid in   flush and restart at redirect_pc
//   redirect_pc    in   new fetch PC (bits [1:0] are forced to zero)
//   deq_ready      in   fetch stage takes the head entry this cycle
//   instr_valid    out  FIFO is non-empty
//   instr          out  head instruction word (0 when empty)
//   instr_pc       out  PC of the head instruction (0 when empty)
//   mem_req        out  registered read request
//   mem_addr       out  registered, word-aligned read address
//   mem_ack        in   read data valid (only meaningful while mem_req=1)
//   mem_rdata      in   read data, valid with mem_ack
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        deq_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // IDLE: nothing outstanding; WAIT: outstanding read whose data is kept;
  // DROP: outstanding read whose data must be thrown away after a redirect.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     data_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];

  logic            push;
  logic            pop;
  logic            space;
  logic [31:0]     redirect_pc_aligned;
  logic [31:0]     fetch_pc_inc;

  assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_pc_inc        = fetch_pc_q + 32'd4;

  // A redirect outranks both push and pop: the queue is emptied and the head
  // is not consumed, and any word arriving in that same cycle is dropped.
  assign pop  = (count_q != '0) && deq_ready && !redirect_valid;
  assign push = (state_q == WAIT) && mem_ack && !redirect_valid;

  // FIFO occupancy and pointers for next cycle. Pointers are PW bits wide
  // so they wrap modulo DEPTH on their own.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // A new read may only be launched if, after this cycle's push/pop, the
  // slot it will fill is still free. Because the previous read has already
  // been pushed (or was never outstanding) when we launch, this reduces to a
  // strict check on next-cycle occupancy.
  assign space = (count_d < CW'(DEPTH));

  // Next-state and memory-request logic.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc_aligned;
        end else if (space) begin
          state_d    = WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc_aligned;
          if (mem_ack) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end else begin
            // Request must stay stable until acked, so keep mem_req/mem_addr
            // and just remember that the data is no longer wanted.
            state_d = DROP;
          end
        end else if (mem_ack) begin
          fetch_pc_d = fetch_pc_inc;
          if (space) begin
            mem_addr_d = fetch_pc_inc;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      DROP: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc_aligned;
        end
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Control registers; reset is asynchronous so mem_req drops immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible while count_q > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_rdata;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? data_mem[rd_ptr_q] : 32'd0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : 32'd0;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer
// Directed scenarios followed by a randomized run of instr_prefetch_buffer,
// with every output compared each cycle against a transaction-level model
// (a queue of {pc, word} entries plus an outstanding-read flag).
module tb_instr_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int vectors;
  int miscompares;

  // Reference model state
  logic [63:0] mQ[$];
  bit          mOut;
  bit          mDiscard;
  bit          mFresh;
  logic [31:0] mFetch;
  logic [31:0] mAddr;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Return the model to its post-reset condition.
  task automatic resetModel();
    mQ.delete();
    mOut     = 1'b0;
    mDiscard = 1'b0;
    mFresh   = 1'b0;
    mFetch   = RESET_PC;
    mAddr    = 32'd0;
  endtask

  // Advance the model across one clock edge using this cycle's inputs.
  task automatic modelEdge(input bit rv, input logic [31:0] rpc, input bit dr,
                           input bit ack, input logic [31:0] rdata);
    bit wasOut;
    bit acked;
    bit doPop;
    bit canIssue;
    wasOut = mOut;
    acked  = mOut && ack;
    doPop  = (mQ.size() > 0) && dr && !rv;
    mFresh = 1'b0;
    if (rv) begin
      mQ.delete();
      mFetch = {rpc[31:2], 2'b00};
      if (acked) begin
        mOut     = 1'b0;
        mDiscard = 1'b0;
      end else if (mOut) begin
        mDiscard = 1'b1;
      end
    end else begin
      canIssue = !wasOut;
      if (doPop) void'(mQ.pop_front());
      if (acked) begin
        mOut = 1'b0;
        if (!mDiscard) begin
          mQ.push_back({mFetch, rdata});
          mFetch   = mFetch + 32'd4;
          canIssue = 1'b1;
        end
        mDiscard = 1'b0;
      end
      if (canIssue && (mQ.size() < DEPTH)) begin
        mOut   = 1'b1;
        mAddr  = mFetch;
        mFresh = !wasOut;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the model's view.
  task automatic checkOutput(input string tag);
    logic [31:0] eInstr;
    logic [31:0] ePc;
    eInstr = 32'd0;
    ePc    = 32'd0;
    if (mQ.size() > 0) begin
      ePc    = mQ[0][63:32];
      eInstr = mQ[0][31:0];
    end
    cmp({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, mQ.size() > 0});
    cmp({tag, ".instr"},       instr,                eInstr);
    cmp({tag, ".instr_pc"},    instr_pc,             ePc);
    cmp({tag, ".mem_req"},     {31'd0, mem_req},     {31'd0, mOut});
    cmp({tag, ".mem_addr"},    mem_addr,             mAddr);
  endtask

  // Drive one cycle of inputs at the falling edge, step the model at the
  // rising edge and check just after it. The memory only acks a request
  // that was already high during the previous cycle.
  task automatic applyStimulus(input bit rv, input logic [31:0] rpc, input bit dr,
                               input bit ackWant, input string tag);
    logic [31:0] rd;
    @(negedge clk);
    rd             = $urandom;
    redirect_valid = rv;
    redirect_pc    = rpc;
    deq_ready      = dr;
    mem_ack        = ackWant && mOut && !mFresh;
    mem_rdata      = rd;
    @(posedge clk);
    modelEdge(rv, rpc, dr, mem_ack, rd);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    deq_ready      = 1'b0;
    mem_ack        = 1'b0;
    mem_rdata      = 32'd0;
    resetModel();
    #1;
    checkOutput(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    deq_ready      = 1'b0;
    mem_ack        = 1'b0;
    mem_rdata      = 32'd0;
    resetModel();

    // Streaming: ack one cycle after req, fetch stage always ready.
    doReset("rst0");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, "stream");

    // Fill to DEPTH with fetch stalled, then one pop reopens a slot (0x10).
    doReset("rst1");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, "fill");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, "pop1");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, "refill");

    // Redirect while a read is waiting; its late data must be dropped.
    doReset("rst2");
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, "issue");
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, "hold");
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, "redirDrop");
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, "drop1");
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, "drop2");
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, "dropAck");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, "after100");

    // Redirect coincident with ack and deq_ready: no push, no pop.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, "prep200");
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, "redirAck");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, "after200");

    // Unaligned redirect target, then wrap of the fetch PC past the top.
    applyStimulus(1'b1, 32'h203, 1'b1, 1'b1, "redir203");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, "after203");
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, "redirTop");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, "wrap");

    // Async reset in the middle of a request with two entries queued.
    doReset("rst3");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, "two");
    @(negedge clk);
    #2;
    rst = 1'b1;
    resetModel();
    #1;
    checkOutput("asyncRst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, "postRst");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit          rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      applyStimulus(rv, rpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
